// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/write-back slice: func codes, widths,
// immediate sign-extension and func validity.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IMM_W      = 16;

    typedef enum logic [3:0] {
        FN_NOP = 4'd0,
        FN_ADD = 4'd1,
        FN_SUB = 4'd2,
        FN_AND = 4'd3,
        FN_OR  = 4'd4,
        FN_XOR = 4'd5,
        FN_NOT = 4'd6,
        FN_SLA = 4'd7,
        FN_SRA = 4'd8,
        FN_SRL = 4'd9
    } alu_fn_e;

    function automatic logic [DATA_W_DEF-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W_DEF-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    function automatic logic fn_is_valid(input logic [3:0] fn);
        return (fn >= FN_ADD) && (fn <= FN_SRL);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear of every entry.
module regfile_2r1w #(
    parameter int NREGS  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_wb.sv
// Operand-issue and write-back stage around a registered ALU (E then W stage).
// Optional ALU_ISSUE_ZERO_REG_EN makes r0 a hardwired zero register.
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    // Issue: transfer when issue_valid && issue_ready at posedge clk;
    // issue_ready never looks at issue_valid.
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_func,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_use_imm,
    input  logic [15:0]       issue_imm,
    output logic [DATA_W-1:0] alu_inp1,
    output logic [DATA_W-1:0] alu_inp2,
    output logic [3:0]        alu_func,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    logic              r_e_valid;
    logic              r_e_writes;
    logic [ADDR_W-1:0] r_e_rd;
    logic              r_w_valid;
    logic              r_w_writes;
    logic [ADDR_W-1:0] r_w_rd;

    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_fn_valid;
    logic              w_rd_writes;
    logic              w_hazard;
    logic              w_accept;
    logic              w_ld_we;
    logic              w_rf_we;
    logic [ADDR_W-1:0] w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;

    regfile_2r1w #(
        .NREGS (NREGS),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_rf_we),
        .i_waddr  (w_rf_waddr),
        .i_wdata  (w_rf_wdata),
        .i_raddr_a(issue_rs),
        .i_raddr_b(issue_rt),
        .o_rdata_a(w_rf_a),
        .o_rdata_b(w_rf_b)
    );

    assign w_imm_ext  = DATA_W'(signed'(sext_imm(issue_imm)));
    assign w_fn_valid = fn_is_valid(issue_func);

`ifdef ALU_ISSUE_ZERO_REG_EN
    // A write aimed at r0 is dropped at issue, so it never stalls or forwards.
    assign w_rd_writes = w_fn_valid && (issue_rd != '0);
    assign w_ld_we     = ld_en && ld_ready && (ld_addr != '0);
`else
    assign w_rd_writes = w_fn_valid;
    assign w_ld_we     = ld_en && ld_ready;
`endif

    assign wb_valid = r_w_valid && r_w_writes;
    assign wb_rd    = r_w_rd;
    assign wb_data  = alu_out;
    assign ld_ready = !wb_valid;

    // The W result is written to the file at the same edge a reader would
    // consume it, so it is forwarded instead of read stale.
    always_comb begin
        w_op_a = w_rf_a;
        w_op_b = w_rf_b;
        if (wb_valid && (r_w_rd == issue_rs)) begin
            w_op_a = alu_out;
        end
        if (wb_valid && (r_w_rd == issue_rt)) begin
            w_op_b = alu_out;
        end
`ifdef ALU_ISSUE_ZERO_REG_EN
        if (issue_rs == '0) begin
            w_op_a = '0;
        end
        if (issue_rt == '0) begin
            w_op_b = '0;
        end
`endif
        if (issue_use_imm) begin
            w_op_b = w_imm_ext;
        end
    end

    // E result is not yet available from the ALU, so a reader must wait one cycle.
    assign w_hazard = r_e_valid && r_e_writes &&
                      ((r_e_rd == issue_rs) || ((r_e_rd == issue_rt) && !issue_use_imm));
    assign issue_ready = !ld_en && !w_hazard;
    assign w_accept    = issue_valid && issue_ready;

    assign w_rf_we    = wb_valid || w_ld_we;
    assign w_rf_waddr = wb_valid ? r_w_rd  : ld_addr;
    assign w_rf_wdata = wb_valid ? alu_out : ld_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e_valid  <= 1'b0;
            r_e_writes <= 1'b0;
            r_e_rd     <= '0;
            r_w_valid  <= 1'b0;
            r_w_writes <= 1'b0;
            r_w_rd     <= '0;
            alu_inp1   <= '0;
            alu_inp2   <= '0;
            alu_func   <= FN_NOP;
        end else begin
            r_w_valid  <= r_e_valid;
            r_w_writes <= r_e_writes;
            r_w_rd     <= r_e_rd;
            if (w_accept) begin
                r_e_valid  <= 1'b1;
                r_e_writes <= w_rd_writes;
                r_e_rd     <= issue_rd;
                alu_inp1   <= w_op_a;
                alu_inp2   <= w_op_b;
                alu_func   <= w_fn_valid ? issue_func : FN_NOP;
            end else begin
                r_e_valid  <= 1'b0;
                r_e_writes <= 1'b0;
                alu_func   <= FN_NOP;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with a behavioural registered ALU model.
module tb_alu_issue_wb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_func;
    logic [3:0]  issue_rs;
    logic [3:0]  issue_rt;
    logic [3:0]  issue_rd;
    logic        issue_use_imm;
    logic [15:0] issue_imm;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [3:0]  alu_func;
    logic [31:0] alu_out;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_imm;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_issue_wb #(.DATA_W(32), .NREGS(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
        .issue_use_imm(issue_use_imm), .issue_imm(issue_imm),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_func(alu_func), .alu_out(alu_out),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    // Downstream ALU: registers its result, holds output when func is 0.
    always @(posedge clk) begin
        if (!reset) begin
            alu_out <= '0;
        end else begin
            case (alu_func)
                4'd1: alu_out <= alu_inp1 + alu_inp2;
                4'd2: alu_out <= alu_inp1 - alu_inp2;
                4'd3: alu_out <= alu_inp1 & alu_inp2;
                4'd4: alu_out <= alu_inp1 | alu_inp2;
                4'd5: alu_out <= alu_inp1 ^ alu_inp2;
                4'd6: alu_out <= ~alu_inp1;
                4'd7: alu_out <= alu_inp1 << alu_inp2[4:0];
                4'd8: alu_out <= 32'($signed(alu_inp1) >>> alu_inp2[4:0]);
                4'd9: alu_out <= alu_inp1 >> alu_inp2[4:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] addr, input logic [31:0] data);
        int n;
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        n = 0;
        @(negedge clk);
        while (!ld_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!ld_ready) chk("load_timeout", 32'(ld_ready), 32'd1);
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Returns 1 time unit after the accepting edge (E stage live).
    task automatic do_issue(input logic [3:0] fn, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [3:0] rd, input logic ui, input logic [15:0] imm);
        int n;
        issue_valid   = 1'b1;
        issue_func    = fn;
        issue_rs      = rs;
        issue_rt      = rt;
        issue_rd      = rd;
        issue_use_imm = ui;
        issue_imm     = imm;
        n = 0;
        @(negedge clk);
        while (!issue_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!issue_ready) chk("issue_timeout", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1 issue_valid = 1'b0;
    endtask

    // Reads a register via OR rX = rX | 0 and checks the issued operand.
    task automatic read_reg(input logic [3:0] r, input logic [31:0] exp, input string name);
        do_issue(4'd4, r, 4'd0, r, 1'b1, 16'h0000);
        chk(name, alu_inp1, exp);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        do_load(4'd1, v.a);
        do_load(4'd2, v.b);
        do_issue(v.fn, 4'd1, 4'd2, 4'd3, v.use_imm, v.imm);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, "_wbv"}, 32'(wb_valid), 32'd1);
        chk({v.name, "_data"}, wb_data, v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"add",     4'd1, 32'd7,        32'd3,        1'b0, 16'h0000, 32'd10};
        vecs[1]  = '{"sub_neg", 4'd2, 32'd3,        32'd7,        1'b0, 16'h0000, 32'hFFFF_FFFC};
        vecs[2]  = '{"and",     4'd3, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 16'h0000, 32'h0000_F000};
        vecs[3]  = '{"or",      4'd4, 32'h0000_F0F0, 32'h0000_0F0F, 1'b0, 16'h0000, 32'h0000_FFFF};
        vecs[4]  = '{"xor",     4'd5, 32'h0000_00FF, 32'h0000_000F, 1'b0, 16'h0000, 32'h0000_00F0};
        vecs[5]  = '{"not",     4'd6, 32'h0000_FFFF, 32'd0,        1'b0, 16'h0000, 32'hFFFF_0000};
        vecs[6]  = '{"sra_imm", 4'd8, 32'hFFFF_FFF0, 32'd0,        1'b1, 16'h0002, 32'hFFFF_FFFC};
        vecs[7]  = '{"srl_imm", 4'd9, 32'hFFFF_FFF0, 32'd0,        1'b1, 16'h0002, 32'h3FFF_FFFC};
        vecs[8]  = '{"sla_imm", 4'd7, 32'hFFFF_FFF0, 32'd0,        1'b1, 16'h0004, 32'hFFFF_FF00};
        vecs[9]  = '{"add_sext", 4'd1, 32'd10,      32'd0,        1'b1, 16'hFFFF, 32'd9};
        vecs[10] = '{"srl_reg", 4'd9, 32'h8000_0000, 32'd8,        1'b0, 16'h0000, 32'h0080_0000};

        reset = 1'b0; issue_valid = 1'b0; issue_func = '0; issue_rs = '0; issue_rt = '0;
        issue_rd = '0; issue_use_imm = 1'b0; issue_imm = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        chk("rst_func", 32'(alu_func), 32'd0);
        chk("rst_inp1", alu_inp1, 32'd0);
        chk("rst_inp2", alu_inp2, 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_ldrdy", 32'(ld_ready), 32'd1);
        chk("rst_issrdy", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset while ADD r2=r1+r1 is in the E stage.
        do_load(4'd1, 32'd5);
        do_issue(4'd1, 4'd1, 4'd1, 4'd2, 1'b0, 16'h0);
        chk("midrst_func_e", 32'(alu_func), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_func", 32'(alu_func), 32'd0);
        chk("midrst_wbv", 32'(wb_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_wbv2", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        read_reg(4'd2, 32'd0, "midrst_r2");
        read_reg(4'd1, 32'd0, "midrst_r1");

        // Basic SUB with write-back timing.
        do_load(4'd1, 32'd7);
        do_load(4'd2, 32'd3);
        do_issue(4'd2, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0);
        chk("sub_func", 32'(alu_func), 32'd2);
        @(negedge clk);
        chk("sub_wbv_e", 32'(wb_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("sub_wbv", 32'(wb_valid), 32'd1);
        chk("sub_data", wb_data, 32'd4);
        chk("sub_rd", 32'(wb_rd), 32'd3);
        @(posedge clk);
        @(negedge clk);
        chk("sub_wbv_off", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        read_reg(4'd3, 32'd4, "sub_r3");

        // Back-to-back dependency: one bubble, then forward from W.
        do_issue(4'd1, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0);
        issue_valid = 1'b1; issue_func = 4'd5; issue_rs = 4'd3; issue_rt = 4'd1;
        issue_rd = 4'd4; issue_use_imm = 1'b0;
        @(negedge clk);
        chk("haz_stall", 32'(issue_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("haz_release", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1 issue_valid = 1'b0;
        chk("haz_fwd_a", alu_inp1, 32'd10);
        chk("haz_b", alu_inp2, 32'd7);
        chk("haz_func", 32'(alu_func), 32'd5);
        @(posedge clk);
        @(negedge clk);
        chk("haz_wb_data", wb_data, 32'd13);
        chk("haz_wb_rd", 32'(wb_rd), 32'd4);
        @(posedge clk);
        #1;
        read_reg(4'd4, 32'd13, "haz_r4");
        read_reg(4'd3, 32'd10, "haz_r3");

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Load collides with the W write; issue is blocked while ld_en is held.
        do_load(4'd1, 32'd7);
        do_issue(4'd1, 4'd1, 4'd1, 4'd6, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        ld_en = 1'b1; ld_addr = 4'd5; ld_data = 32'd9;
        issue_valid = 1'b1; issue_func = 4'd4; issue_rs = 4'd1; issue_rd = 4'd7;
        issue_use_imm = 1'b1; issue_imm = 16'h0;
        @(negedge clk);
        chk("col_ldrdy", 32'(ld_ready), 32'd0);
        chk("col_issrdy", 32'(issue_ready), 32'd0);
        chk("col_wbv", 32'(wb_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("col_ldrdy2", 32'(ld_ready), 32'd1);
        chk("col_issrdy2", 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        issue_valid = 1'b0;
        read_reg(4'd5, 32'd9, "col_r5");
        read_reg(4'd6, 32'd14, "col_r6");

        // Invalid func is a NOP: no write-back, no stall for its readers.
        do_issue(4'hF, 4'd1, 4'd1, 4'd8, 1'b0, 16'h0);
        chk("nop_func", 32'(alu_func), 32'd0);
        issue_valid = 1'b1; issue_func = 4'd4; issue_rs = 4'd8; issue_rd = 4'd9;
        issue_use_imm = 1'b1; issue_imm = 16'h0;
        @(negedge clk);
        chk("nop_nostall", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1 issue_valid = 1'b0;
        chk("nop_r8", alu_inp1, 32'd0);
        @(negedge clk);
        chk("nop_wbv", 32'(wb_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("nop_next_wbv", 32'(wb_valid), 32'd1);
        chk("nop_next_rd", 32'(wb_rd), 32'd9);
        @(posedge clk);
        #1;

`ifdef ALU_ISSUE_ZERO_REG_EN
        do_load(4'd0, 32'h55);
        read_reg(4'd0, 32'd0, "zr_ld_r0");
        do_issue(4'd1, 4'd1, 4'd1, 4'd0, 1'b0, 16'h0);
        issue_valid = 1'b1; issue_func = 4'd1; issue_rs = 4'd0; issue_rt = 4'd0;
        issue_rd = 4'd10; issue_use_imm = 1'b0;
        @(negedge clk);
        chk("zr_nostall", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1 issue_valid = 1'b0;
        chk("zr_src0", alu_inp1, 32'd0);
        @(negedge clk);
        chk("zr_wbv", 32'(wb_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        read_reg(4'd0, 32'd0, "zr_r0");
`else
        do_load(4'd0, 32'h55);
        read_reg(4'd0, 32'h55, "r0_plain");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
